// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter: two one-entry requester buffers share the register file write port.
// Round-robin grant, registered write stage, and a pending-write bitmap for decode stalls.
module rf_wb_arbiter #(
  parameter  int DSIZE = 16,
  parameter  int RSIZE = 4,
  localparam int NREG  = 2**RSIZE
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             A_Valid,
  input  logic [RSIZE-1:0] A_Addr,
  input  logic [DSIZE-1:0] A_Data,
  output logic             A_Ready,
  input  logic             B_Valid,
  input  logic [RSIZE-1:0] B_Addr,
  input  logic [DSIZE-1:0] B_Data,
  output logic             B_Ready,
  output logic             Wen,
  output logic [RSIZE-1:0] WAddr,
  output logic [DSIZE-1:0] WData,
  output logic [NREG-1:0]  Pending
);

  typedef enum logic {PTR_A = 1'b0, PTR_B = 1'b1} ptr_e;

  logic             r_a_full;
  logic [RSIZE-1:0] r_a_addr;
  logic [DSIZE-1:0] r_a_data;
  logic             r_b_full;
  logic [RSIZE-1:0] r_b_addr;
  logic [DSIZE-1:0] r_b_data;
  ptr_e             r_ptr;
  logic             r_wen;
  logic [RSIZE-1:0] r_waddr;
  logic [DSIZE-1:0] r_wdata;

  logic w_a_zero, w_b_zero;
  logic w_a_elig, w_b_elig;
  logic w_gnt_a, w_gnt_b;
  logic w_a_free, w_b_free;
  logic w_a_load, w_b_load;
  logic [NREG-1:0] w_pend;

  // Writes to R0 are dropped in the buffer: freed at once, no grant, pointer untouched.
  assign w_a_zero = r_a_full && (r_a_addr == '0);
  assign w_b_zero = r_b_full && (r_b_addr == '0);
  assign w_a_elig = r_a_full && (r_a_addr != '0);
  assign w_b_elig = r_b_full && (r_b_addr != '0);

  assign w_gnt_a = w_a_elig && (!w_b_elig || (r_ptr == PTR_A));
  assign w_gnt_b = w_b_elig && (!w_a_elig || (r_ptr == PTR_B));

  assign w_a_free = w_gnt_a || w_a_zero;
  assign w_b_free = w_gnt_b || w_b_zero;

  assign A_Ready = !Reset && (!r_a_full || w_a_free);
  assign B_Ready = !Reset && (!r_b_full || w_b_free);

  assign w_a_load = A_Valid && A_Ready;
  assign w_b_load = B_Valid && B_Ready;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_a_full <= 1'b0;
      r_b_full <= 1'b0;
      r_ptr    <= PTR_A;
      r_wen    <= 1'b0;
      r_waddr  <= '0;
      r_wdata  <= '0;
    end else begin
      r_a_full <= (r_a_full && !w_a_free) || w_a_load;
      r_b_full <= (r_b_full && !w_b_free) || w_b_load;
      r_wen    <= w_gnt_a || w_gnt_b;
      if (w_gnt_a) begin
        r_waddr <= r_a_addr;
        r_wdata <= r_a_data;
        r_ptr   <= PTR_B;
      end else if (w_gnt_b) begin
        r_waddr <= r_b_addr;
        r_wdata <= r_b_data;
        r_ptr   <= PTR_A;
      end
    end
  end

  // Buffer payloads only matter while the matching full flag is set, so they skip reset.
  always_ff @(posedge Clock) begin
    if (w_a_load) begin
      r_a_addr <= A_Addr;
      r_a_data <= A_Data;
    end
    if (w_b_load) begin
      r_b_addr <= B_Addr;
      r_b_data <= B_Data;
    end
  end

  always_comb begin
    w_pend = '0;
    if (r_a_full) w_pend[r_a_addr] = 1'b1;
    if (r_b_full) w_pend[r_b_addr] = 1'b1;
    if (r_wen)    w_pend[r_waddr]  = 1'b1;
    w_pend[0] = 1'b0;
  end

  assign Pending = w_pend;
  assign Wen     = r_wen;
  assign WAddr   = r_waddr;
  assign WData   = r_wdata;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: expected register-file writes go into a queue,
// a negedge monitor pops and compares each Wen cycle; Ready/Pending are checked inline.
module tb_rf_wb_arbiter;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        A_Valid = 1'b0;
  logic [3:0]  A_Addr = '0;
  logic [15:0] A_Data = '0;
  logic        A_Ready;
  logic        B_Valid = 1'b0;
  logic [3:0]  B_Addr = '0;
  logic [15:0] B_Data = '0;
  logic        B_Ready;
  logic        Wen;
  logic [3:0]  WAddr;
  logic [15:0] WData;
  logic [15:0] Pending;

  rf_wb_arbiter #(.DSIZE(16), .RSIZE(4)) dut (
    .Clock(Clock), .Reset(Reset),
    .A_Valid(A_Valid), .A_Addr(A_Addr), .A_Data(A_Data), .A_Ready(A_Ready),
    .B_Valid(B_Valid), .B_Addr(B_Addr), .B_Data(B_Data), .B_Ready(B_Ready),
    .Wen(Wen), .WAddr(WAddr), .WData(WData), .Pending(Pending)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
  } wr_t;

  wr_t         exp_q[$];
  int          nvec = 0;
  int          nmis = 0;
  logic [15:0] rf [16];

  always @(posedge Clock) if (Wen === 1'b1) rf[WAddr] <= WData;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge Clock) begin
    if (Wen === 1'b1) begin
      wr_t e;
      if (exp_q.size() == 0) begin
        nvec++;
        nmis++;
        $display("FAIL unexpected_write: got WAddr=%0d WData=0x%0h expected none at %0t",
                 WAddr, WData, $time);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", {28'd0, WAddr}, {28'd0, e.a});
        chk("write_data", {16'd0, WData}, {16'd0, e.d});
      end
    end
  end

  task automatic nxt();
    @(posedge Clock);
    #1;
  endtask

  task automatic smp();
    @(negedge Clock);
  endtask

  task automatic push(input logic [3:0] a, input logic [15:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic offer_a(input logic v, input logic [3:0] a, input logic [15:0] d);
    A_Valid = v; A_Addr = a; A_Data = d;
  endtask

  task automatic offer_b(input logic v, input logic [3:0] a, input logic [15:0] d);
    B_Valid = v; B_Addr = a; B_Data = d;
  endtask

  task automatic idle_drain(input int n, input string name);
    offer_a(1'b0, 4'd0, 16'd0);
    offer_b(1'b0, 4'd0, 16'd0);
    repeat (n) nxt();
    smp();
    chk(name, exp_q.size(), 0);
    nxt();
  endtask

  task automatic do_reset();
    offer_a(1'b0, 4'd0, 16'd0);
    offer_b(1'b0, 4'd0, 16'd0);
    Reset = 1'b1;
    nxt();
    Reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit expa [6];
    bit expb [6];
    int acc_a;
    int acc_b;
    expa = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    expb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 16; i++) rf[i] = '0;

    // Reset state
    nxt();
    nxt();
    Reset = 1'b0;
    smp();
    chk("rst_wen", {31'd0, Wen}, 0);
    chk("rst_waddr", {28'd0, WAddr}, 0);
    chk("rst_wdata", {16'd0, WData}, 0);
    chk("rst_pending", {16'd0, Pending}, 0);
    chk("rst_a_ready", {31'd0, A_Ready}, 1);
    chk("rst_b_ready", {31'd0, B_Ready}, 1);
    nxt();

    // 1: single uncontended write
    offer_a(1'b1, 4'd3, 16'h1234);
    push(4'd3, 16'h1234);
    smp();
    chk("t1_a_ready", {31'd0, A_Ready}, 1);
    chk("t1_pend_pre", {16'd0, Pending}, 0);
    nxt();
    offer_a(1'b0, 4'd0, 16'd0);
    smp();
    chk("t1_pend_buf", {31'd0, Pending[3]}, 1);
    chk("t1_wen_e0", {31'd0, Wen}, 0);
    nxt();
    smp();
    chk("t1_wen_e1", {31'd0, Wen}, 1);
    chk("t1_pend_wen", {31'd0, Pending[3]}, 1);
    nxt();
    smp();
    chk("t1_pend_after", {16'd0, Pending}, 0);
    chk("t1_wen_after", {31'd0, Wen}, 0);
    nxt();
    idle_drain(2, "t1_drain");

    // 2: both requesters every cycle from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push(4'd5, 16'hAAAA);
      push(4'd6, 16'hBBBB);
    end
    acc_a = 0;
    acc_b = 0;
    for (int k = 0; k <= 10; k++) begin
      offer_a(acc_a < 4, 4'd5, 16'hAAAA);
      offer_b(acc_b < 4, 4'd6, 16'hBBBB);
      smp();
      if (k < 6) begin
        chk($sformatf("t2_a_ready_%0d", k), {31'd0, A_Ready}, {31'd0, expa[k]});
        chk($sformatf("t2_b_ready_%0d", k), {31'd0, B_Ready}, {31'd0, expb[k]});
      end
      chk($sformatf("t2_wen_%0d", k), {31'd0, Wen}, (k >= 2 && k <= 9) ? 1 : 0);
      if (A_Valid && A_Ready) acc_a++;
      if (B_Valid && B_Ready) acc_b++;
      nxt();
    end
    idle_drain(2, "t2_drain");

    // 3: B writes R0 while A writes R7 (pointer is A here)
    offer_a(1'b1, 4'd7, 16'h7777);
    offer_b(1'b1, 4'd0, 16'hFFFF);
    push(4'd7, 16'h7777);
    smp();
    chk("t3_a_ready", {31'd0, A_Ready}, 1);
    chk("t3_b_ready", {31'd0, B_Ready}, 1);
    nxt();
    offer_a(1'b0, 4'd0, 16'd0);
    offer_b(1'b0, 4'd0, 16'd0);
    smp();
    chk("t3_pend0_c1", {31'd0, Pending[0]}, 0);
    chk("t3_pend7_c1", {31'd0, Pending[7]}, 1);
    chk("t3_b_freed", {31'd0, B_Ready}, 1);
    nxt();
    smp();
    chk("t3_pend0_c2", {31'd0, Pending[0]}, 0);
    chk("t3_wen_r7", {31'd0, Wen}, 1);
    nxt();
    // Pointer should now favour B
    offer_a(1'b1, 4'd11, 16'h0A0A);
    offer_b(1'b1, 4'd12, 16'h0B0B);
    push(4'd12, 16'h0B0B);
    push(4'd11, 16'h0A0A);
    nxt();
    idle_drain(4, "t3_drain");

    // 6: same-address contention with pointer at B
    offer_a(1'b1, 4'd4, 16'h0001);
    offer_b(1'b1, 4'd4, 16'h0002);
    push(4'd4, 16'h0002);
    push(4'd4, 16'h0001);
    nxt();
    offer_a(1'b0, 4'd0, 16'd0);
    offer_b(1'b0, 4'd0, 16'd0);
    for (int k = 1; k <= 4; k++) begin
      smp();
      chk($sformatf("t6_pend4_%0d", k), {31'd0, Pending[4]}, (k <= 3) ? 1 : 0);
      nxt();
    end
    smp();
    chk("t6_rf4", {16'd0, rf[4]}, 32'h0001);
    nxt();
    idle_drain(2, "t6_drain");

    // 4: A streams R1..R8 back-to-back
    for (int i = 0; i < 8; i++) push(4'(i + 1), 16'h1000 + 16'(i));
    for (int k = 0; k <= 10; k++) begin
      if (k < 8) offer_a(1'b1, 4'(k + 1), 16'h1000 + 16'(k));
      else       offer_a(1'b0, 4'd0, 16'd0);
      smp();
      if (k < 8) chk($sformatf("t4_a_ready_%0d", k), {31'd0, A_Ready}, 1);
      chk($sformatf("t4_wen_%0d", k), {31'd0, Wen}, (k >= 2 && k <= 9) ? 1 : 0);
      nxt();
    end
    idle_drain(2, "t4_drain");

    // 5: reset with both buffers full discards them
    offer_a(1'b1, 4'd9, 16'h9999);
    offer_b(1'b1, 4'd10, 16'hA0A0);
    nxt();
    offer_a(1'b0, 4'd0, 16'd0);
    offer_b(1'b0, 4'd0, 16'd0);
    Reset = 1'b1;
    smp();
    chk("t5_a_ready_rst", {31'd0, A_Ready}, 0);
    chk("t5_b_ready_rst", {31'd0, B_Ready}, 0);
    nxt();
    Reset = 1'b0;
    smp();
    chk("t5_pending", {16'd0, Pending}, 0);
    chk("t5_a_ready", {31'd0, A_Ready}, 1);
    chk("t5_b_ready", {31'd0, B_Ready}, 1);
    chk("t5_wen", {31'd0, Wen}, 0);
    chk("t5_waddr", {28'd0, WAddr}, 0);
    nxt();
    idle_drain(4, "t5_drain");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (Wen/WAddr/WData) between two writeback requesters: port A (ALU result) and port B (memory load return).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- Buffered writes are granted round-robin and issued through a registered output stage that drives the register file directly.
- A pending-write bitmap is exported so decode can stall reads of registers whose writes are still in flight.

Parameters:
DSIZE, 16, data word width
RSIZE, 4, register address width; register count NREG = 2**RSIZE

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous reset, active-high
A_Valid  in  1  requester A offers a write
A_Addr  in  RSIZE  requester A destination register
A_Data  in  DSIZE  requester A write data
A_Ready  out  1  requester A offer accepted this edge
B_Valid  in  1  requester B offers a write
B_Addr  in  RSIZE  requester B destination register
B_Data  in  DSIZE  requester B write data
B_Ready  out  1  requester B offer accepted this edge
Wen  out  1  write enable to register file (registered)
WAddr  out  RSIZE  write address to register file (registered)
WData  out  DSIZE  write data to register file (registered)
Pending  out  NREG  bit r = 1 while a write to register r is buffered or on the output stage

Behaviour:
- Reset (Reset=1 at a rising edge): both buffers empty, Wen=0, WAddr=0, WData=0, priority pointer = A. Any buffered writes are discarded, not issued. The same edge accepts no offers.
- State per buffer X ∈ {A,B}: full flag, Addr, Data.
- Zero-write rule: a full buffer with Addr=0 is "zero-write". R0 is constant 0.
  - A zero-write never drives Wen.
  - It is freed in its first full cycle, regardless of the other buffer.
  - It does not consume a grant and does not move the pointer.
- Eligibility: a buffer is eligible when it is full and not zero-write.
- Grant (combinational, each cycle):
  - If only one buffer is eligible, it wins.
  - If both are eligible, the pointer side wins.
  - If none is eligible, there is no grant.
- At the rising edge after a grant:
  - Wen=1; WAddr/WData = the winner's contents.
  - The winner's buffer is freed.
  - The pointer moves to the loser side.
- With no grant: Wen=0; WAddr/WData hold their previous values.
- Ready: X_Ready = !Reset && (buffer X empty || buffer X freed this cycle). This gives the full-throughput pass-through case.
- Accept: if X_Valid && X_Ready at an edge, buffer X loads X_Addr/X_Data and becomes full. A simultaneous free and load of the same buffer leaves it full with the new contents.
- Latency, uncontended: offer accepted at edge E0 → Wen=1 during the cycle after E1 → register file captures at E2.
- Throughput: sustained single-requester rate is 1 write/cycle. Under contention, each requester gets 1 write per 2 cycles.
- Requester obligation: X_Valid, once asserted, holds with stable Addr/Data until accepted. The arbiter does not check this.
- Same-address contention: the two writes issue in grant order (later grant wins in the register file). There is no merging.
- Pending[r] = (A full && A.Addr=r && r≠0) | (B full && B.Addr=r && r≠0) | (Wen && WAddr=r). It is combinational from registered state, and Pending[0] is always 0.
- Wen never asserts with WAddr=0.

Test Plan:
1. Reset, then A offers (Addr=3, Data=0x1234) for one cycle → A_Ready=1 at E0; Wen=1, WAddr=3, WData=0x1234 after E1; Pending[3]=1 from after E0 through the Wen cycle, then 0.
2. A and B both offer every cycle, A→R5 (0xAAAA), B→R6 (0xBBBB), from reset → issue order A,B,A,B,…; each Ready pulses once every 2 cycles after the first; Wen continuously 1 from the first issue.
3. B offers Addr=0 (Data=0xFFFF) while A offers Addr=7 → B freed without issue, Wen only for R7, pointer still set to B afterwards, Pending[0] stays 0.
4. A streams 8 back-to-back writes to R1..R8 with B idle → A_Ready held 1, Wen held 1 for 8 consecutive cycles, addresses 1..8 in order.
5. Both buffers full (A→R9, B→R10); Reset asserted for one edge → no Wen for R9 or R10; Pending=0, both Ready=1 in the cycle after Reset deasserts.
6. A and B both target R4 (A=0x0001, B=0x0002) with pointer=B → issue B then A; final register 4 content 0x0001; Pending[4] stays 1 until the second Wen cycle ends.
